// File: rtl/fsm_pkg.sv
// Shared helpers for serial pattern detectors: state sizing, idle state
// constant and the elaboration-time KMP next-state function.
package fsm_pkg;

    localparam int S_IDLE = 0;

    // Bits needed to hold a prefix length in 0..n.
    function automatic int state_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    // KMP-style transition for a prefix-length state machine. The pattern
    // MSB is the first received bit. When s == pat_w and overlap is clear,
    // the history is dropped and only x is considered against the first bit.
    function automatic int next_state(
        input logic [63:0] pattern,
        input int          pat_w,
        input int          s,
        input logic        x,
        input bit          overlap
    );
        logic [64:0] seq;
        int          len;
        int          kmax;
        int          res;
        logic        ok;
        res = 0;
        seq = 65'd0;
        if ((s >= pat_w) && !overlap) begin
            res = (x == pattern[6'(pat_w - 1)]) ? 1 : 0;
        end else begin
            // Rebuild the accepted history: the matched prefix then x.
            for (int i = 0; i < s; i++) begin
                seq[7'(i)] = pattern[6'(pat_w - 1 - i)];
            end
            seq[7'(s)] = x;
            len  = s + 1;
            kmax = (len > pat_w) ? pat_w : len;
            // Longest suffix of the history that is also a pattern prefix.
            for (int k = kmax; k >= 1; k--) begin
                if (res == 0) begin
                    ok = 1'b1;
                    for (int j = 0; j < k; j++) begin
                        if (seq[7'(len - k + j)] != pattern[6'(pat_w - 1 - j)]) begin
                            ok = 1'b0;
                        end else begin
                            ok = ok;
                        end
                    end
                    if (ok) begin
                        res = k;
                    end else begin
                        res = 0;
                    end
                end else begin
                    res = res;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear wins, otherwise step unless already saturated.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = {W{1'b0}};
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Count register with asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= {W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/moore_seq_detector.sv
// Parametrised Moore serial pattern detector. State is the length of the
// longest pattern prefix ending the accepted history; transitions come from
// a table built at elaboration from PATTERN.
module moore_seq_detector
    import fsm_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1101,
    parameter bit               OVERLAP = 1'b1,
    parameter int               CNT_W   = 8,
    localparam int              SW      = state_width(PAT_W)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             clear,
    input  logic             x,
    output logic [SW-1:0]    state,
    output logic             y,
    output logic [CNT_W-1:0] match_count
);

    localparam logic [SW-1:0] S_ZERO = SW'(S_IDLE);
    localparam logic [SW-1:0] S_FULL = SW'(PAT_W);

    logic [SW-1:0] ns_table [0:PAT_W][0:1];
    logic [SW-1:0] state_q;
    logic [SW-1:0] state_d;
    logic          y_q;
    logic          inc_s;

    // Constant transition table, one entry per (state, input bit).
    for (genvar gs = 0; gs <= PAT_W; gs++) begin : g_state
        for (genvar gb = 0; gb < 2; gb++) begin : g_bit
            localparam int NS = next_state(64'(PATTERN), PAT_W, gs, gb[0], OVERLAP);
            assign ns_table[gs][gb] = SW'(NS);
        end
    end

    // Table lookup; unreachable encodings fall back to idle.
    always_comb begin
        state_d = S_ZERO;
        if (state_q <= S_FULL) begin
            state_d = ns_table[state_q][x];
        end else begin
            state_d = S_ZERO;
        end
    end

    // Count every enabled, non-cleared step that lands in the full state.
    assign inc_s = en && !clear && (state_d == S_FULL);

    // State and Moore output registers: reset, then clear, then enable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_ZERO;
            y_q     <= 1'b0;
        end else if (clear) begin
            state_q <= S_ZERO;
            y_q     <= 1'b0;
        end else if (en) begin
            state_q <= state_d;
            y_q     <= (state_d == S_FULL);
        end else begin
            state_q <= state_q;
            y_q     <= y_q;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (clear),
        .inc     (inc_s),
        .count   (match_count)
    );

    assign state = state_q;
    assign y     = y_q;

endmodule
